// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared constants for the pipeline control unit.
//   - stall masks: bit 0 pc, 1 if, 2 id, 3 ex, 4 mem, 5 wb
//   - exception vector bit position of MRET
//   - FSM state encodings and the hold/drain counter width
//   - stall_map(): stage stall requests -> stall mask
// Optional feature macro: PIPE_CTRL_DEBUG_HALT_EN (adds the debug states).
package pipe_ctrl_pkg;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] MASK_PC    = 6'b000001;
    localparam logic [5:0] MASK_IF    = 6'b000011;
    localparam logic [5:0] MASK_ID    = 6'b000111;
    localparam logic [5:0] MASK_EX    = 6'b001111;
    localparam logic [5:0] MASK_MEM   = 6'b011111;

    // Bits [30:0] carry trap causes (misaligned 0, illegal 2, ebreak 3,
    // ecall 11); bit 31 flags an MRET in MEM.
    localparam int EXC_MRET = 31;

    localparam int CNT_W = 8;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_TRAP_HOLD = 3'd1;
`ifdef PIPE_CTRL_DEBUG_HALT_EN
    localparam logic [2:0] ST_DRAIN     = 3'd2;
    localparam logic [2:0] ST_HALTED    = 3'd3;
    localparam logic [2:0] ST_RESUME    = 3'd4;
`endif

    // The deepest requesting stage wins; its mask also freezes every
    // stage in front of it.
    function automatic logic [5:0] stall_map(input logic req_if, input logic req_id,
                                             input logic req_ex, input logic req_mem);
        if (req_mem)     return MASK_MEM;
        else if (req_ex) return MASK_EX;
        else if (req_id) return MASK_ID;
        else if (req_if) return MASK_IF;
        else             return STALL_NONE;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: bundle between the pipeline datapath and pipe_ctrl.
//   master: pipeline side (drives requests, consumes stall/flush/redirect)
//   slave : pipe_ctrl side
// Signalling: there is no back-pressure anywhere in this bundle. Every *_i
// is a level sampled in the cycle it is presented; new_pc_valid_o is a
// single-cycle qualifier for new_pc_o that the PC register must accept in
// that same cycle. csr_trap_we_o, mret_o and resume_ack_o are 1-cycle pulses.
// dbg_state_o exposes the controller FSM state for observation.
interface pipe_ctrl_if;
    logic        stallreq_if_i;
    logic        stallreq_id_i;
    logic        stallreq_ex_i;
    logic        stallreq_mem_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] exception_i;
    logic [31:0] exception_pc_i;
    logic [31:0] mtvec_i;
    logic [31:0] mepc_i;
    logic        halt_req_i;
    logic        resume_req_i;
    logic [5:0]  stall_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic        new_pc_valid_o;
    logic        csr_trap_we_o;
    logic [31:0] csr_mepc_o;
    logic [31:0] csr_mcause_o;
    logic        mret_o;
    logic        halted_o;
    logic        resume_ack_o;
    logic [2:0]  dbg_state_o;

    modport master (
        output stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
        output redirect_i, redirect_pc_i, exception_i, exception_pc_i,
        output mtvec_i, mepc_i, halt_req_i, resume_req_i,
        input  stall_o, flush_o, new_pc_o, new_pc_valid_o, csr_trap_we_o,
        input  csr_mepc_o, csr_mcause_o, mret_o, halted_o, resume_ack_o, dbg_state_o
    );

    modport slave (
        input  stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
        input  redirect_i, redirect_pc_i, exception_i, exception_pc_i,
        input  mtvec_i, mepc_i, halt_req_i, resume_req_i,
        output stall_o, flush_o, new_pc_o, new_pc_valid_o, csr_trap_we_o,
        output csr_mepc_o, csr_mcause_o, mret_o, halted_o, resume_ack_o, dbg_state_o
    );
endinterface

// File: rtl/pipe_ctrl_cause_enc.sv
// pipe_ctrl_cause_enc: exception vector -> mcause.
//   exception_i : exception vector of the instruction in MEM
//   trap_o      : some cause bit in [30:0] is set
//   is_mret_o   : only the MRET flag (bit 31) is set
//   mcause_o    : index of the lowest set bit in [30:0]
module pipe_ctrl_cause_enc
    import pipe_ctrl_pkg::*;
(
    input  logic [31:0] exception_i,
    output logic        trap_o,
    output logic        is_mret_o,
    output logic [31:0] mcause_o
);

    // Scan downwards so the lowest set bit is the last one written.
    always_comb begin
        trap_o   = 1'b0;
        mcause_o = '0;
        for (int i = EXC_MRET - 1; i >= 0; i--) begin
            if (exception_i[i]) begin
                trap_o   = 1'b1;
                mcause_o = 32'(i);
            end
        end
    end

    // MRET ranks below every real trap cause.
    assign is_mret_o = exception_i[EXC_MRET] && !trap_o;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control unit. Builds stall_o/flush_o for the PC and
// pipeline registers from stage stall requests, EX branch redirects and
// MEM-stage traps/MRET, and sequences trap entry.
// Ports:
//   clk_i, n_rst_i : clock, asynchronous active-low reset
//   bus            : pipe_ctrl_if.slave (requests in; stall/flush/redirect/CSR out)
// Parameters:
//   TRAP_HOLD_CYCLES : cycles the PC stays stalled after a trap/MRET flush (>=1)
//   DRAIN_CYCLES     : bubble cycles before halted_o (debug build only)
// Optional feature macro: PIPE_CTRL_DEBUG_HALT_EN adds debug halt/resume
// (DRAIN -> HALTED -> RESUME). Without it halt/resume requests are ignored.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TRAP_HOLD_CYCLES = 1,
    parameter int DRAIN_CYCLES     = 4
) (
    input  logic      clk_i,
    input  logic      n_rst_i,
    pipe_ctrl_if.slave bus
);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        trap, is_mret, take_trap, take_mret, accept_events;
    logic [31:0] mcause;
    logic [5:0]  stall;
    logic        flush, npc_valid, trap_we, mret;
    logic [31:0] npc, mepc_out, mcause_out;
`ifdef PIPE_CTRL_DEBUG_HALT_EN
    logic        halted, resume_ack;
`endif

    pipe_ctrl_cause_enc u_cause_enc (
        .exception_i (bus.exception_i),
        .trap_o      (trap),
        .is_mret_o   (is_mret),
        .mcause_o    (mcause)
    );

    // An instruction in MEM that is itself stalled has not committed yet.
    assign take_trap = trap && !bus.stallreq_mem_i;
    assign take_mret = is_mret && !bus.stallreq_mem_i;

`ifdef PIPE_CTRL_DEBUG_HALT_EN
    // While draining for a halt, traps and redirects still resolve first.
    assign accept_events = (state_q == ST_IDLE) || (state_q == ST_DRAIN);
`else
    assign accept_events = (state_q == ST_IDLE);
    logic unused_dbg;
    assign unused_dbg = ^{bus.halt_req_i, bus.resume_req_i, 32'(DRAIN_CYCLES)};
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stall      = stall_map(bus.stallreq_if_i, bus.stallreq_id_i,
                               bus.stallreq_ex_i, bus.stallreq_mem_i);
        flush      = 1'b0;
        npc_valid  = 1'b0;
        npc        = '0;
        trap_we    = 1'b0;
        mepc_out   = '0;
        mcause_out = '0;
        mret       = 1'b0;
`ifdef PIPE_CTRL_DEBUG_HALT_EN
        halted     = 1'b0;
        resume_ack = 1'b0;
`endif

        if (accept_events) begin
            if (take_trap) begin
                flush      = 1'b1;
                npc_valid  = 1'b1;
                npc        = bus.mtvec_i;
                trap_we    = 1'b1;
                mepc_out   = bus.exception_pc_i;
                mcause_out = mcause;
                state_d    = ST_TRAP_HOLD;
                cnt_d      = CNT_W'(TRAP_HOLD_CYCLES);
            end else if (take_mret) begin
                flush     = 1'b1;
                npc_valid = 1'b1;
                npc       = bus.mepc_i;
                mret      = 1'b1;
                state_d   = ST_TRAP_HOLD;
                cnt_d     = CNT_W'(TRAP_HOLD_CYCLES);
            end else if (bus.redirect_i) begin
                flush     = 1'b1;
                npc_valid = 1'b1;
                npc       = bus.redirect_pc_i;
            end
        end

        case (state_q)
            ST_IDLE: begin
`ifdef PIPE_CTRL_DEBUG_HALT_EN
                if (!flush && bus.halt_req_i) begin
                    state_d = ST_DRAIN;
                    cnt_d   = CNT_W'(DRAIN_CYCLES);
                end
`endif
            end
            ST_TRAP_HOLD: begin
                stall = stall | MASK_PC;
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`ifdef PIPE_CTRL_DEBUG_HALT_EN
            ST_DRAIN: begin
                stall = stall | MASK_IF;
                // A flush this cycle either left for TRAP_HOLD or
                // refilled the front end, so the drain count pauses.
                if (!flush) begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = ST_HALTED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            ST_HALTED: begin
                stall  = stall | MASK_IF;
                halted = 1'b1;
                if (bus.resume_req_i) state_d = ST_RESUME;
            end
            ST_RESUME: begin
                resume_ack = 1'b1;
                state_d    = ST_IDLE;
            end
`endif
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // A flush empties every register, so nothing is left to hold.
        if (flush) stall = STALL_NONE;
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.stall_o        = stall;
    assign bus.flush_o        = flush;
    assign bus.new_pc_o       = npc;
    assign bus.new_pc_valid_o = npc_valid;
    assign bus.csr_trap_we_o  = trap_we;
    assign bus.csr_mepc_o     = mepc_out;
    assign bus.csr_mcause_o   = mcause_out;
    assign bus.mret_o         = mret;
    assign bus.dbg_state_o    = state_q;
`ifdef PIPE_CTRL_DEBUG_HALT_EN
    assign bus.halted_o       = halted;
    assign bus.resume_ack_o   = resume_ack;
`else
    assign bus.halted_o       = 1'b0;
    assign bus.resume_ack_o   = 1'b0;
`endif

endmodule
